// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg -- shared types for the memory arbiter slice.
//   ramstate_t  : RAM status codes as presented on ramstate.
//   arb_state_t : arbiter FSM states.
//   timer_width : counter width for the optional access timeout
//                 (MEM_ARBITER_TIMEOUT_EN), never narrower than 8 bits.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2,
    RESP = 2'd3
  } arb_state_t;

  // Bits needed to count up to limit, with an 8-bit floor.
  function automatic int timer_width(input int limit);
    int w;
    w = $clog2(limit + 1);
    if (w < 8) begin
      w = 8;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/mem_arbiter_fsm_if.sv
// mem_arbiter_fsm_if -- datapath request/response and RAM bus bundle.
//   Datapath side : iREN, iaddr, dREN, dWEN, daddr, dstore -> ihit, iload,
//                   dhit, dload (and memerr with MEM_ARBITER_TIMEOUT_EN).
//   RAM side      : ramREN, ramWEN, ramaddr, ramstore -> ramload, ramstate.
// Modports: master = datapath, slave = arbiter, ram = RAM model.
interface mem_arbiter_fsm_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import cpu_types_pkg::*;

  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic              ihit;
  logic [DATA_W-1:0] iload;
  logic              dhit;
  logic [DATA_W-1:0] dload;
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  ramstate_t         ramstate;
`ifdef MEM_ARBITER_TIMEOUT_EN
  logic              memerr;
`endif

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore,
    input  ihit, iload, dhit, dload
`ifdef MEM_ARBITER_TIMEOUT_EN
    , input memerr
`endif
  );

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore
`ifdef MEM_ARBITER_TIMEOUT_EN
    , output memerr
`endif
  );

  modport ram (
    input  ramREN, ramWEN, ramaddr, ramstore,
    output ramload, ramstate
  );

endinterface

// File: rtl/mem_arbiter_fsm_access_timer.sv
// access_timer -- cycle counter for the optional access timeout.
// Only built with MEM_ARBITER_TIMEOUT_EN.
//   clk, rst : clock, async active-high reset
//   clear    : zero the count (asserted on the way into an access state)
//   active   : count this cycle (FSM is in an access state)
//   expired  : this cycle is the TIMEOUT-th one spent in the access state
`ifdef MEM_ARBITER_TIMEOUT_EN
module access_timer
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic active,
  output logic expired
);

  localparam int CNT_W = timer_width(TIMEOUT);

  logic [CNT_W-1:0] count_r;

  // Cycles spent in the current access state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (active) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  // The count starts at 0 in the first access cycle, so TIMEOUT-1 marks the last one.
  assign expired = active && (count_r == CNT_W'(TIMEOUT - 1));

endmodule
`endif

// File: rtl/mem_arbiter_fsm.sv
// mem_arbiter_fsm -- serialises instruction-fetch and data requests onto a
// single-port RAM; data requests win over fetches.
//   CLK, RST : clock (rising edge), async active-high reset
//   bus      : mem_arbiter_fsm_if.slave (datapath requests/hits, RAM bus)
// Optional: MEM_ARBITER_TIMEOUT_EN aborts an access after TIMEOUT cycles
// without ACCESS, returning zero load data with memerr pulsed alongside the hit.
module mem_arbiter_fsm
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             CLK,
  input  logic             RST,
  mem_arbiter_fsm_if.slave bus
);

  arb_state_t        state_r, next_state_s;
  logic              is_data_r, is_data_s;
  logic              req_wen_r, req_wen_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [DATA_W-1:0] store_r, store_s;
  logic              ram_ren_r, ram_ren_s;
  logic              ram_wen_r, ram_wen_s;
  logic              ihit_r, ihit_s;
  logic              dhit_r, dhit_s;
  logic [DATA_W-1:0] iload_r, iload_s;
  logic [DATA_W-1:0] dload_r, dload_s;
`ifdef MEM_ARBITER_TIMEOUT_EN
  logic              memerr_r, memerr_s;
  logic              timer_clear_s, timer_active_s, timer_expired_s;

  assign timer_clear_s  = (state_r == IDLE) && (next_state_s != IDLE);
  assign timer_active_s = (state_r == IACC) || (state_r == DACC);

  access_timer #(.TIMEOUT(TIMEOUT)) u_access_timer (
    .clk     (CLK),
    .rst     (RST),
    .clear   (timer_clear_s),
    .active  (timer_active_s),
    .expired (timer_expired_s)
  );
`endif

  // Next state and next values of every registered output.
  always_comb begin
    next_state_s = state_r;
    is_data_s    = is_data_r;
    req_wen_s    = req_wen_r;
    addr_s       = addr_r;
    store_s      = store_r;
    ram_ren_s    = ram_ren_r;
    ram_wen_s    = ram_wen_r;
    ihit_s       = 1'b0;
    dhit_s       = 1'b0;
    iload_s      = iload_r;
    dload_s      = dload_r;
`ifdef MEM_ARBITER_TIMEOUT_EN
    memerr_s     = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (bus.dWEN) begin
          next_state_s = DACC;
          is_data_s    = 1'b1;
          req_wen_s    = 1'b1;
          addr_s       = bus.daddr;
          store_s      = bus.dstore;
          ram_ren_s    = 1'b0;
          ram_wen_s    = 1'b1;
        end else if (bus.dREN) begin
          next_state_s = DACC;
          is_data_s    = 1'b1;
          req_wen_s    = 1'b0;
          addr_s       = bus.daddr;
          ram_ren_s    = 1'b1;
          ram_wen_s    = 1'b0;
        end else if (bus.iREN) begin
          next_state_s = IACC;
          is_data_s    = 1'b0;
          req_wen_s    = 1'b0;
          addr_s       = bus.iaddr;
          ram_ren_s    = 1'b1;
          ram_wen_s    = 1'b0;
        end else begin
          next_state_s = IDLE;
          ram_ren_s    = 1'b0;
          ram_wen_s    = 1'b0;
        end
      end
      IACC, DACC: begin
        if (bus.ramstate == ACCESS) begin
          next_state_s = RESP;
          ram_ren_s    = 1'b0;
          ram_wen_s    = 1'b0;
          if (is_data_r) begin
            dhit_s = 1'b1;
            if (!req_wen_r) begin
              dload_s = bus.ramload;
            end else begin
              dload_s = dload_r;
            end
          end else begin
            ihit_s  = 1'b1;
            iload_s = bus.ramload;
          end
        end
`ifdef MEM_ARBITER_TIMEOUT_EN
        else if (timer_expired_s) begin
          next_state_s = RESP;
          ram_ren_s    = 1'b0;
          ram_wen_s    = 1'b0;
          memerr_s     = 1'b1;
          if (is_data_r) begin
            dhit_s  = 1'b1;
            dload_s = '0;
          end else begin
            ihit_s  = 1'b1;
            iload_s = '0;
          end
        end
`endif
        else begin
          next_state_s = state_r;
        end
      end
      RESP: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
        ram_ren_s    = 1'b0;
        ram_wen_s    = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r   <= IDLE;
      is_data_r <= 1'b0;
      req_wen_r <= 1'b0;
      addr_r    <= '0;
      store_r   <= '0;
      ram_ren_r <= 1'b0;
      ram_wen_r <= 1'b0;
      ihit_r    <= 1'b0;
      dhit_r    <= 1'b0;
      iload_r   <= '0;
      dload_r   <= '0;
`ifdef MEM_ARBITER_TIMEOUT_EN
      memerr_r  <= 1'b0;
`endif
    end else begin
      state_r   <= next_state_s;
      is_data_r <= is_data_s;
      req_wen_r <= req_wen_s;
      addr_r    <= addr_s;
      store_r   <= store_s;
      ram_ren_r <= ram_ren_s;
      ram_wen_r <= ram_wen_s;
      ihit_r    <= ihit_s;
      dhit_r    <= dhit_s;
      iload_r   <= iload_s;
      dload_r   <= dload_s;
`ifdef MEM_ARBITER_TIMEOUT_EN
      memerr_r  <= memerr_s;
`endif
    end
  end

  assign bus.ramREN   = ram_ren_r;
  assign bus.ramWEN   = ram_wen_r;
  assign bus.ramaddr  = addr_r;
  assign bus.ramstore = store_r;
  assign bus.ihit     = ihit_r;
  assign bus.dhit     = dhit_r;
  assign bus.iload    = iload_r;
  assign bus.dload    = dload_r;
`ifdef MEM_ARBITER_TIMEOUT_EN
  assign bus.memerr   = memerr_r;
`endif

endmodule

// File: tb/tb_mem_arbiter_fsm.sv
// tb_mem_arbiter_fsm -- scoreboard bench for mem_arbiter_fsm.
// A behavioural RAM answers with a programmable number of BUSY/ERROR cycles
// before ACCESS. Each request pushes its expected hit onto a queue; a monitor
// pops and compares on every ihit/dhit.
`timescale 1ns/1ps
module tb_mem_arbiter_fsm;
  import cpu_types_pkg::*;

  localparam int TB_TIMEOUT = 4;
`ifdef MEM_ARBITER_TIMEOUT_EN
  localparam int ERR_CYC  = 2;
  localparam int RAND_DLY = 2;
`else
  localparam int ERR_CYC  = 5;
  localparam int RAND_DLY = 4;
`endif

  typedef struct {
    bit          is_data;
    logic [31:0] data;
    bit          err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_fsm_if bus ();

  mem_arbiter_fsm #(.TIMEOUT(TB_TIMEOUT)) dut (.CLK(clk), .RST(rst), .bus(bus));

  int          total_cnt = 0;
  int          bad_cnt   = 0;
  int          hit_cnt   = 0;
  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [31:0] ram_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] pred_dload = 32'h0;
  int          ram_delay  = 0;
  int          acc_cnt    = 0;
  ramstate_t   ram_wait_st = BUSY;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pattern(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] ref_val(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return pattern(a);
  endfunction

  // Behavioural RAM: delay cycles of ram_wait_st, then ACCESS.
  always @(negedge clk) begin
    if (rst || !(bus.ramREN || bus.ramWEN)) begin
      bus.ramstate = FREE;
      acc_cnt      = 0;
    end else if (acc_cnt < ram_delay) begin
      bus.ramstate = ram_wait_st;
      acc_cnt++;
    end else begin
      bus.ramstate = ACCESS;
      if (bus.ramWEN) begin
        ram_mem[bus.ramaddr] = bus.ramstore;
      end else begin
        bus.ramload = ram_mem.exists(bus.ramaddr) ? ram_mem[bus.ramaddr] : pattern(bus.ramaddr);
      end
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!rst && (bus.ihit || bus.dhit)) begin
      hit_cnt++;
      chk("hit_onehot", 64'(bus.ihit & bus.dhit), 64'd0);
      if (sb_q.size() == 0) begin
        chk("spurious_hit", 64'(sb_q.size()), 64'd1);
      end else begin
        mon_e = sb_q.pop_front();
        chk("hit_kind", 64'(bus.dhit), 64'(mon_e.is_data));
        chk("hit_data", 64'(bus.dhit ? bus.dload : bus.iload), 64'(mon_e.data));
`ifdef MEM_ARBITER_TIMEOUT_EN
        chk("hit_err", 64'(bus.memerr), 64'(mon_e.err));
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_reqs();
    bus.iREN = 1'b0;
    bus.dREN = 1'b0;
    bus.dWEN = 1'b0;
  endtask

  // kind: 0 fetch, 1 load, 2 store
  task automatic do_req(input int kind, input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    e.err = 1'b0;
    case (kind)
      0: begin
        bus.iREN = 1'b1; bus.iaddr = addr;
        e.is_data = 1'b0; e.data = ref_val(addr);
      end
      1: begin
        bus.dREN = 1'b1; bus.daddr = addr;
        e.is_data = 1'b1; e.data = ref_val(addr); pred_dload = e.data;
      end
      default: begin
        bus.dWEN = 1'b1; bus.daddr = addr; bus.dstore = wdata;
        e.is_data = 1'b1; e.data = pred_dload; ref_mem[addr] = wdata;
      end
    endcase
    sb_q.push_back(e);
  endtask

  task automatic wait_hit(input int max_cyc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      tick();
      if (bus.ihit || bus.dhit) seen = 1'b1;
    end
    chk("hit_wait", 64'(seen), 64'd1);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ihit"},     64'(bus.ihit),     64'd0);
    chk({tag, "_dhit"},     64'(bus.dhit),     64'd0);
    chk({tag, "_ramREN"},   64'(bus.ramREN),   64'd0);
    chk({tag, "_ramWEN"},   64'(bus.ramWEN),   64'd0);
    chk({tag, "_ramaddr"},  64'(bus.ramaddr),  64'd0);
    chk({tag, "_ramstore"}, 64'(bus.ramstore), 64'd0);
    chk({tag, "_iload"},    64'(bus.iload),    64'd0);
    chk({tag, "_dload"},    64'(bus.dload),    64'd0);
`ifdef MEM_ARBITER_TIMEOUT_EN
    chk({tag, "_memerr"},   64'(bus.memerr),   64'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int hc;
    bus.iREN = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
    bus.iaddr = 32'h0; bus.daddr = 32'h0; bus.dstore = 32'h0;
    bus.ramload = 32'h0; bus.ramstate = FREE;
    ram_mem[32'h40]  = 32'h3C01_0001; ref_mem[32'h40]  = 32'h3C01_0001;
    ram_mem[32'h100] = 32'hCAFE_F00D; ref_mem[32'h100] = 32'hCAFE_F00D;

    repeat (3) tick();
    chk_outputs_zero("reset");
    rst = 1'b0;
    tick();

    ram_delay = 0;
    do_req(0, 32'h40, 32'h0);
    tick();
    chk("f_ramREN",  64'(bus.ramREN),  64'd1);
    chk("f_ramWEN",  64'(bus.ramWEN),  64'd0);
    chk("f_ramaddr", 64'(bus.ramaddr), 64'h40);
    tick();
    chk("f_ihit",  64'(bus.ihit),  64'd1);
    chk("f_iload", 64'(bus.iload), 64'h3C01_0001);
    drop_reqs();
    tick();
    chk("f_ihit_once", 64'(bus.ihit), 64'd0);
    chk("f_ren_drop",  64'(bus.ramREN), 64'd0);

    ram_delay = 1;
    do_req(1, 32'h100, 32'h0);
    do_req(0, 32'h44, 32'h0);
    wait_hit(10);
    chk("pri_dfirst", 64'(bus.dhit), 64'd1);
    bus.dREN = 1'b0;
    wait_hit(10);
    chk("pri_ithen", 64'(bus.ihit), 64'd1);
    drop_reqs();
    tick();

    ram_delay = 3; ram_wait_st = BUSY;
    do_req(2, 32'h80, 32'hDEAD_BEEF);
    bus.dREN = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("st_ramWEN",   64'(bus.ramWEN),   64'd1);
      chk("st_ramREN",   64'(bus.ramREN),   64'd0);
      chk("st_ramstore", 64'(bus.ramstore), 64'hDEAD_BEEF);
      chk("st_dhit_early", 64'(bus.dhit),   64'd0);
      tick();
    end
    chk("st_dhit",  64'(bus.dhit),  64'd1);
    chk("st_dload", 64'(bus.dload), 64'(pred_dload));
    drop_reqs();
    tick();

    ram_delay = 0;
    do_req(1, 32'h80, 32'h0);
    wait_hit(10);
    chk("rb_dload", 64'(bus.dload), 64'hDEAD_BEEF);
    drop_reqs();
    tick();

    ram_delay = ERR_CYC; ram_wait_st = ERROR;
    do_req(0, 32'h48, 32'h0);
    tick();
    for (int k = 0; k <= ERR_CYC; k++) begin
      chk("err_ramREN",  64'(bus.ramREN),  64'd1);
      chk("err_ramaddr", 64'(bus.ramaddr), 64'h48);
      chk("err_ihit_early", 64'(bus.ihit), 64'd0);
      tick();
    end
    chk("err_ihit", 64'(bus.ihit), 64'd1);
    drop_reqs();
    tick();

    ram_delay = 10; ram_wait_st = BUSY;
    bus.dWEN = 1'b1; bus.daddr = 32'h200; bus.dstore = 32'h1234_5678;
    tick();
    tick();
    chk("rst_pre_ramWEN", 64'(bus.ramWEN), 64'd1);
    rst = 1'b1;
    #1;
    chk_outputs_zero("midrst");
    drop_reqs();
    tick();
    rst = 1'b0;
    pred_dload = 32'h0;
    hc = hit_cnt;
    repeat (12) tick();
    chk("rst_no_hit", 64'(hit_cnt - hc), 64'd0);
    chk("rst_idle_ramWEN", 64'(bus.ramWEN), 64'd0);

    for (int n = 0; n < 12; n++) begin
      int          kind;
      logic [31:0] a;
      kind        = int'($urandom_range(0, 2));
      a           = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      ram_delay   = int'($urandom_range(0, RAND_DLY));
      ram_wait_st = ($urandom_range(0, 1) == 0) ? BUSY : ERROR;
      do_req(kind, a, $urandom);
      wait_hit(20);
      drop_reqs();
      tick();
    end

`ifdef MEM_ARBITER_TIMEOUT_EN
    begin
      exp_t e;
      ram_delay = 1000; ram_wait_st = BUSY;
      bus.iREN = 1'b1; bus.iaddr = 32'h60;
      e.is_data = 1'b0; e.data = 32'h0; e.err = 1'b1;
      sb_q.push_back(e);
      tick();
      repeat (TB_TIMEOUT - 1) tick();
      chk("to_ihit_early", 64'(bus.ihit), 64'd0);
      tick();
      chk("to_ihit",   64'(bus.ihit),   64'd1);
      chk("to_memerr", 64'(bus.memerr), 64'd1);
      chk("to_iload",  64'(bus.iload),  64'd0);
      drop_reqs();
      tick();
      chk("to_memerr_once", 64'(bus.memerr), 64'd0);
    end
`endif

    repeat (3) tick();
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_fsm.md
Name: mem_arbiter_fsm

Overview:
- Responder end of the datapath memory-request interface: accepts instruction fetch requests (iREN) and data requests (dREN/dWEN) from the datapath.
- Serialises those requests onto a single-port RAM and returns ihit/dhit with the load data.
- Sits between the datapath (driven by the control unit's iREN/dREN/dWEN) and the RAM model.
- Data requests take priority over instruction fetches.

Parameters:
- ADDR_W, 32, width of iaddr/daddr/ramaddr.
- DATA_W, 32, width of load/store data.
- TIMEOUT, 255, cycles in an access state before abort (used only with the optional feature).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset; asynchronous, active-high.
- iREN  in  1  instruction fetch request.
- iaddr  in  ADDR_W  fetch address.
- dREN  in  1  data load request.
- dWEN  in  1  data store request.
- daddr  in  ADDR_W  data address.
- dstore  in  DATA_W  store data.
- ihit  out  1  one-cycle fetch-complete pulse.
- iload  out  DATA_W  fetched instruction.
- dhit  out  1  one-cycle data-complete pulse.
- dload  out  DATA_W  loaded data.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  DATA_W  RAM write data.
- ramload  in  DATA_W  RAM read data.
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.

Behaviour:
- Reset (async, RST=1): state=IDLE; ihit, dhit, ramREN, ramWEN = 0; ramaddr, ramstore, iload, dload = 0; latched request registers cleared.
- IDLE:
  - If dWEN, latch daddr/dstore and wen=1, go DACC.
  - Else if dREN, latch daddr and wen=0, go DACC.
  - Else if iREN, latch iaddr, go IACC.
  - Otherwise stay in IDLE.
  - Request inputs are sampled only in IDLE.
- dREN and dWEN together: treated as a store.
- Any data request together with iREN: data is served first. iREN is served on the following IDLE visit if still held.
- IACC: ramREN=1, ramWEN=0, ramaddr = latched addr.
- DACC: ramREN = !wen, ramWEN = wen, ramaddr/ramstore = latched values.
- Enables are registered outputs and are stable for the whole access.
- Completion: when ramstate==ACCESS in IACC/DACC:
  - Capture ramload into iload (IACC) or dload (DACC read). A store leaves dload unchanged.
  - Drop ramREN/ramWEN next cycle and go RESP.
- ramstate BUSY or FREE: stay in the access state.
- ramstate ERROR: stay and keep driving (retry) unless the optional feature aborts.
- RESP: ihit or dhit =1 for exactly this one cycle, then go IDLE. ihit and dhit are never both 1.
- Latency: request in IDLE at cycle N; RAM driven from N+1. If ACCESS is seen at cycle M, the hit is at M+1. With zero-wait RAM (ACCESS at N+1) the hit is at N+2.
- iload/dload hold their last captured value until overwritten.
- Requester deasserting mid-access: the access still completes and the hit still pulses. Requesters must hold requests until the hit.
- Back-to-back requests: at least one IDLE cycle between accesses.

Optional Feature:
- Macro: MEM_ARBITER_TIMEOUT_EN.
- When defined:
  - An 8-bit-or-wider counter (sized from TIMEOUT) clears on entering IACC/DACC and increments each cycle there.
  - When it reaches TIMEOUT with no ACCESS, the block goes RESP, pulses the hit with load data = 0, and asserts extra output memerr (1 bit, one cycle, coincident with the hit).
  - memerr resets to 0.
- When not defined: no counter and no memerr port; the block waits indefinitely.

Decomposition:
- ramstate_t (FREE/BUSY/ACCESS/ERROR) and the arbiter state enum (IDLE, IACC, DACC, RESP) belong in cpu_types_pkg.
- Optional sub-module access_timer (counter plus compare) holds the timeout logic, instantiated only under the macro.

Test Plan:
- Reset mid-DACC (RST pulsed while ramWEN=1) -> all outputs 0 immediately, state IDLE, no dhit afterwards.
- iREN=1, iaddr=0x40, RAM returns ACCESS at cycle 1 with ramload=0x3C010001 -> ramREN=1, ramaddr=0x40 at cycle 1; ihit=1, iload=0x3C010001 at cycle 2.
- iREN=1 and dREN=1 together, daddr=0x100 -> DACC first: dhit, dload=ramload. Then IACC: ihit. Never both hits in the same cycle.
- dWEN=1 and dREN=1, daddr=0x80, dstore=0xDEADBEEF, RAM BUSY 3 cycles then ACCESS -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF throughout; dhit 1 cycle after ACCESS; dload unchanged.
- ramstate=ERROR for 5 cycles then ACCESS -> retry holds ram signals, hit one cycle after ACCESS.
- With MEM_ARBITER_TIMEOUT_EN and TIMEOUT=4, RAM stuck BUSY -> ihit=1, memerr=1, iload=0 four cycles after entering IACC.
